iccm_port_ctrl: RTL and testbench

//  Single-port scheduler for the instruction SRAM (DFFRAM, 1-cycle read latency).

---
 rtl/iccm_port_ctrl_pkg.sv | 9 +
 rtl/iccm_port_ctrl_if.sv | 31 +++
 rtl/iccm_port_ctrl_arb.sv | 24 ++
 rtl/iccm_port_ctrl.sv | 54 +++++
 tb/tb_iccm_port_ctrl.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/iccm_port_ctrl_pkg.sv
// iccm_port_ctrl_pkg: shared state type and sizing helpers for the ICCM port controller
package iccm_port_ctrl_pkg;
    typedef enum logic {BOOT = 1'b0, RUN = 1'b1} iccm_state_e;
    localparam int AW_DEF = 12;
    localparam int DW_DEF = 32;
    function automatic int mask_w(input int dw);
        return dw / 8;
    endfunction
endpackage

// File: rtl/iccm_port_ctrl_if.sv
// iccm_port_ctrl_if: fetch, programming and SRAM macro signals of the ICCM port controller
interface iccm_port_ctrl_if import iccm_port_ctrl_pkg::*; #(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic                 f_req_i;
    logic [AW-1:0]        f_addr_i;
    logic                 f_gnt_o;
    logic [DW-1:0]        f_rdata_o;
    logic                 f_rvalid_o;
    logic                 p_req_i;
    logic [AW-1:0]        p_addr_i;
    logic [DW-1:0]        p_wdata_i;
    logic [mask_w(DW)-1:0] p_wmask_i;
    logic                 p_gnt_o;
    logic                 boot_done_i;
    logic                 fetch_en_o;
    logic                 sram_en_o;
    logic [mask_w(DW)-1:0] sram_we_o;
    logic [AW-1:0]        sram_addr_o;
    logic [DW-1:0]        sram_wdata_o;
    logic [DW-1:0]        sram_rdata_i;
    modport slave (
        input  f_req_i, f_addr_i, p_req_i, p_addr_i, p_wdata_i, p_wmask_i, boot_done_i, sram_rdata_i,
        output f_gnt_o, f_rdata_o, f_rvalid_o, p_gnt_o, fetch_en_o, sram_en_o, sram_we_o, sram_addr_o, sram_wdata_o
    );
    modport master (
        output f_req_i, f_addr_i, p_req_i, p_addr_i, p_wdata_i, p_wmask_i, boot_done_i, sram_rdata_i,
        input  f_gnt_o, f_rdata_o, f_rvalid_o, p_gnt_o, fetch_en_o, sram_en_o, sram_we_o, sram_addr_o, sram_wdata_o
    );
endinterface

// File: rtl/iccm_port_ctrl_arb.sv
// iccm_port_ctrl_arb: fetch-first two-way arbiter with a saturating prog-starvation counter
module iccm_port_ctrl_arb #(
    parameter int STALL_MAX = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       force_en,
    output logic [1:0] gnt
);
    localparam int CW = $clog2(STALL_MAX + 1);
    logic [CW-1:0] stall_q;
    logic starved, p_win;
    assign starved = stall_q == CW'(STALL_MAX);
    assign p_win   = req[1] & (force_en | starved | ~req[0]);
    assign gnt     = {p_win, req[0] & ~force_en & ~p_win};
    // count consecutive denied prog cycles; only meaningful while fetch may compete
    always_ff @(posedge clock) begin
        if (reset || force_en || !req[1] || gnt[1])
            stall_q <= '0;
        else if (!starved)
            stall_q <= stall_q + 1'b1;
    end
endmodule

// File: rtl/iccm_port_ctrl.sv
// iccm_port_ctrl: boot/run sequencing and single-port sharing of the instruction SRAM
module iccm_port_ctrl import iccm_port_ctrl_pkg::*; #(
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF,
    parameter int STALL_MAX = 8,
    parameter int BOOT_HOLD = 1
) (
    input logic clock,
    input logic reset,
    iccm_port_ctrl_if.slave bus
);
    iccm_state_e   state_q, state_d;
    logic [1:0]    gnt;
    logic          rvalid_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;

    iccm_port_ctrl_arb #(.STALL_MAX(STALL_MAX)) u_arb (
        .clock    (clock),
        .reset    (reset),
        .req      ({bus.p_req_i, bus.f_req_i} & {2{!reset}}),
        .force_en (state_q == BOOT),
        .gnt      (gnt)
    );

    // boot state register; reset picks the configured start state
    always_ff @(posedge clock) begin
        state_q <= reset ? (BOOT_HOLD != 0 ? BOOT : RUN) : state_d;
    end

    // leave BOOT only once the loader is done and no write is still outstanding
    always_comb begin
        state_d = state_q;
        if (state_q == BOOT && bus.boot_done_i && !bus.p_req_i)
            state_d = RUN;
    end

    assign bus.f_gnt_o      = gnt[0];
    assign bus.p_gnt_o      = gnt[1];
    assign bus.fetch_en_o   = state_q == RUN && !reset;
    assign bus.sram_en_o    = |gnt;
    assign bus.sram_we_o    = gnt[1] ? bus.p_wmask_i : '0;
    assign bus.sram_addr_o  = gnt[1] ? bus.p_addr_i : gnt[0] ? bus.f_addr_i : addr_q;
    assign bus.sram_wdata_o = gnt[1] ? bus.p_wdata_i : wdata_q;
    assign bus.f_rvalid_o   = rvalid_q && !reset;
    assign bus.f_rdata_o    = bus.f_rvalid_o ? bus.sram_rdata_i : '0;

    // read-valid tracks the macro latency; address/data hold their last driven value when idle
    always_ff @(posedge clock) begin
        rvalid_q <= !reset && gnt[0];
        addr_q   <= reset ? '0 : bus.sram_addr_o;
        wdata_q  <= reset ? '0 : bus.sram_wdata_o;
    end
endmodule

// File: tb/tb_iccm_port_ctrl.sv
// tb_iccm_port_ctrl: directed and randomized checks of iccm_port_ctrl against a cycle-level reference model
module tb_iccm_port_ctrl;
    import iccm_port_ctrl_pkg::*;
    localparam int AW = 12, DW = 32, MW = 4, STALL_MAX = 8, DEPTH = 1 << AW;

    logic clock = 1'b0;
    logic reset = 1'b1;
    iccm_port_ctrl_if #(.AW(AW), .DW(DW)) bus ();
    iccm_port_ctrl #(.AW(AW), .DW(DW), .STALL_MAX(STALL_MAX), .BOOT_HOLD(1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );
    always #5 clock = ~clock;

    function automatic logic [DW-1:0] fill(input int a);
        return DW'(a) * 32'h9E37_79B1 + 32'h1357_2468;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw, input logic [MW-1:0] m);
        logic [DW-1:0] w;
        w = old;
        for (int b = 0; b < MW; b++) if (m[b]) w[8*b +: 8] = nw[8*b +: 8];
        return w;
    endfunction

    // SRAM macro: 1-cycle read latency, byte-masked writes
    logic [DW-1:0] sram [DEPTH];
    bit loaded = 1'b0;
    always @(posedge clock) begin
        if (!loaded) begin
            for (int i = 0; i < DEPTH; i++) sram[i] = fill(i);
            loaded = 1'b1;
        end
        if (bus.sram_en_o) begin
            bus.sram_rdata_i <= sram[bus.sram_addr_o];
            if (|bus.sram_we_o) sram[bus.sram_addr_o] = merge(sram[bus.sram_addr_o], bus.sram_wdata_o, bus.sram_we_o);
        end
    end

    // reference model state
    logic [DW-1:0] ref_mem [DEPTH];
    bit m_run = 1'b0, m_rv = 1'b0;
    int m_stall = 0;
    logic [DW-1:0] m_rd = '0, m_wdata = '0;
    logic [AW-1:0] m_addr = '0;
    bit e_fg, e_pg;
    logic o_fg, o_pg, o_rv, o_fen, o_en;
    logic [DW-1:0] o_rd;
    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock cycle: drive, compare against the model, then advance the model across the edge
    task automatic cyc(input bit r, input bit fr, input logic [AW-1:0] fa, input bit pr, input logic [AW-1:0] pa,
                       input logic [DW-1:0] pd, input logic [MW-1:0] pm, input bit bd);
        @(negedge clock);
        reset = r;
        bus.f_req_i = fr; bus.f_addr_i = fa;
        bus.p_req_i = pr; bus.p_addr_i = pa; bus.p_wdata_i = pd; bus.p_wmask_i = pm;
        bus.boot_done_i = bd;
        #1;
        if (r) begin e_fg = 0; e_pg = 0; end
        else if (!m_run) begin e_fg = 0; e_pg = pr; end
        else if (pr && m_stall >= STALL_MAX) begin e_fg = 0; e_pg = 1; end
        else begin e_fg = fr; e_pg = pr && !fr; end
        o_fg = bus.f_gnt_o; o_pg = bus.p_gnt_o; o_rv = bus.f_rvalid_o; o_rd = bus.f_rdata_o;
        o_fen = bus.fetch_en_o; o_en = bus.sram_en_o;
        chk("f_gnt", o_fg, e_fg);
        chk("p_gnt", o_pg, e_pg);
        chk("fetch_en", o_fen, m_run && !r);
        chk("sram_en", o_en, e_fg || e_pg);
        chk("sram_we", bus.sram_we_o, e_pg ? pm : MW'(0));
        chk("rvalid", o_rv, m_rv && !r);
        chk("rdata", o_rd, (m_rv && !r) ? m_rd : DW'(0));
        if (!r) begin
            chk("sram_addr", bus.sram_addr_o, e_pg ? pa : e_fg ? fa : m_addr);
            chk("sram_wdata", bus.sram_wdata_o, e_pg ? pd : m_wdata);
        end
        @(posedge clock);
        m_rv = e_fg;
        m_rd = ref_mem[fa];
        if (e_pg) ref_mem[pa] = merge(ref_mem[pa], pd, pm);
        if (e_pg || e_fg) m_addr = e_pg ? pa : fa;
        if (e_pg) m_wdata = pd;
        m_stall = (!r && m_run && pr && !e_pg) ? ((m_stall + 1 > STALL_MAX) ? STALL_MAX : m_stall + 1) : 0;
        m_run = !r && (m_run || (bd && !pr));
        if (r) begin m_rv = 0; m_addr = '0; m_wdata = '0; end
    endtask

    bit rr, fr, pr, bd, fh, ph;
    logic [AW-1:0] fa, pa;
    logic [DW-1:0] pd;
    logic [MW-1:0] pm;

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = fill(i);
        bus.f_req_i = 0; bus.f_addr_i = '0; bus.p_req_i = 0; bus.p_addr_i = '0;
        bus.p_wdata_i = '0; bus.p_wmask_i = '0; bus.boot_done_i = 0;
        // reset, then fetch requests are refused while booting
        repeat (2) cyc(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 12'h010, 0, 0, 0, 0, 0);
            chk("t1_fgnt", o_fg, 0);
            chk("t1_fetch_en", o_fen, 0);
            chk("t1_sram_en", o_en, 0);
        end
        // program a word, finish boot, read it back
        cyc(0, 0, 0, 1, 12'h010, 32'hDEAD_BEEF, 4'hF, 0);
        chk("t2_pgnt", o_pg, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 1, 12'h010, 0, 0, 0, 0, 1);
        chk("t2_fetch_en", o_fen, 1);
        chk("t2_fgnt", o_fg, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("t2_rvalid", o_rv, 1);
        chk("t2_rdata", o_rd, 32'hDEAD_BEEF);
        // contention: eight fetch grants then a forced prog grant, repeating
        for (int i = 0; i < 27; i++) begin
            cyc(0, 1, 12'h010, 1, 12'h030, 32'h1234_5678, 4'hF, 1);
            chk("t3_pgnt", o_pg, (i % 9) == 8);
            chk("t3_fgnt", o_fg, (i % 9) != 8);
        end
        // partial byte write merges into the existing word
        cyc(0, 0, 0, 1, 12'h020, 32'hFFFF_FFFF, 4'hF, 1);
        cyc(0, 0, 0, 1, 12'h020, 32'h0000_AAAA, 4'h3, 1);
        cyc(0, 1, 12'h020, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("t4_rdata", o_rd, 32'hFFFF_AAAA);
        // boot_done with a write pending: write wins, RUN waits for the request to drop
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 12'h040, 32'h0000_0055, 4'hF, 1);
        chk("t5_pgnt", o_pg, 1);
        cyc(0, 0, 0, 1, 12'h041, 32'h0000_0066, 4'hF, 1);
        chk("t5_boot_hold", o_fen, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("t5_boot_last", o_fen, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("t5_run", o_fen, 1);
        // reset right after a fetch grant drops the pending read and reinitialises
        cyc(0, 1, 12'h040, 0, 0, 0, 0, 1);
        chk("t6_fgnt", o_fg, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        chk("t6_rvalid", o_rv, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        chk("t6_boot", o_fen, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 9; i++) begin
            cyc(0, 1, 12'h041, 1, 12'h042, 32'h0BAD_F00D, 4'h5, 1);
            chk("t6_stall_clear", o_pg, i == 8);
        end
        // randomized traffic with requests held until granted
        fh = 0; ph = 0;
        for (int i = 0; i < 2500; i++) begin
            rr = $urandom_range(0, 299) == 0;
            if (!fh) begin fr = $urandom_range(0, 2) != 0; fa = AW'($urandom_range(0, 31)); end
            if (!ph) begin
                pr = $urandom_range(0, 3) == 0; pa = AW'($urandom_range(0, 31));
                pd = $urandom; pm = MW'($urandom);
            end
            bd = $urandom_range(0, 7) == 0;
            cyc(rr, fr, fa, pr, pa, pd, pm, bd);
            fh = fr && !o_fg && !rr;
            ph = pr && !o_pg && !rr;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
